// File: rtl/frame_cfg_sched_pkg.sv
`default_nettype none
//==============================================================================
// Module      : frame_cfg_pkg
// Description : Mode/state encodings and default widths for frame_cfg_sched.
// Revision    : 1.0 - initial release
//==============================================================================
package frame_cfg_pkg;

    localparam int DEF_BRIGHT_W    = 8;
    localparam int DEF_BRIGHT_STEP = 8;
    localparam int DEF_CON_W       = 4;
    localparam int DEF_CON_DEF     = 4;

    localparam logic [1:0] MODE_PASS  = 2'd0;
    localparam logic [1:0] MODE_GRAY  = 2'd1;
    localparam logic [1:0] MODE_GREEN = 2'd2;
    localparam logic [1:0] MODE_CDET  = 2'd3;

    localparam logic [0:0] ACTIVE = 1'b0;
    localparam logic [0:0] BLANK  = 1'b1;

    function automatic logic [3:0] mode_onehot(input logic [1:0] m);
        logic [3:0] v;
        v = 4'b0001;
        case (m)
            MODE_PASS:  v = 4'b0001;
            MODE_GRAY:  v = 4'b0010;
            MODE_GREEN: v = 4'b0100;
            MODE_CDET:  v = 4'b1000;
            default:    v = 4'b0001;
        endcase
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/frame_cfg_sched_if.sv
`default_nettype none
//==============================================================================
// Module      : frame_cfg_sched_if
// Description : Control pulses in, committed datapath configuration out.
// Revision    : 1.0 - initial release
//==============================================================================
interface frame_cfg_sched_if #(
    parameter int BRIGHT_W = 8,
    parameter int CON_W    = 4
) ();
    logic                       frame_en;
    logic                       binc;
    logic                       bdec;
    logic                       cinc;
    logic                       cdec;
    logic                       mode_next;
    logic                       mode_lock;
    logic signed [BRIGHT_W-1:0] bright_off;
    logic [CON_W-1:0]           con_gain;
    logic [1:0]                 mode;
    logic [3:0]                 mode_en;
    logic                       cfg_busy;
    logic                       upd_strobe;

    modport master (
        output frame_en, binc, bdec, cinc, cdec, mode_next, mode_lock,
        input  bright_off, con_gain, mode, mode_en, cfg_busy, upd_strobe
    );

    modport slave (
        input  frame_en, binc, bdec, cinc, cdec, mode_next, mode_lock,
        output bright_off, con_gain, mode, mode_en, cfg_busy, upd_strobe
    );
endinterface
`default_nettype wire

// File: rtl/frame_cfg_sched_sat_step_reg.sv
`default_nettype none
//==============================================================================
// Module      : sat_step_reg
// Description : Register stepped up/down by inc/dec pulses, clamped to [MIN,MAX].
// Revision    : 1.0 - initial release
//==============================================================================
module sat_step_reg #(
    parameter int W       = 8,
    parameter bit SIGNED  = 1'b1,
    parameter int STEP    = 1,
    parameter int MIN     = 0,
    parameter int MAX     = 255,
    parameter int RST_VAL = 0
) (
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic         inc,
    input  wire logic         dec,
    output logic [W-1:0]      value,
    output logic [W-1:0]      value_nxt
);
    localparam logic [W-1:0] c_rst = RST_VAL[W-1:0];

    logic [W-1:0] r_val;
    logic [W-1:0] w_nxt;
    logic         w_up_req;
    logic         w_dn_req;

    // Opposing pulses in one cycle cancel out.
    assign w_up_req = inc & ~dec;
    assign w_dn_req = dec & ~inc;

    generate
        if (SIGNED) begin : g_signed
            localparam logic signed [W:0] c_step = STEP[W:0];
            localparam logic signed [W:0] c_min  = MIN[W:0];
            localparam logic signed [W:0] c_max  = MAX[W:0];
            logic signed [W:0] w_cur;
            logic signed [W:0] w_up;
            logic signed [W:0] w_dn;

            assign w_cur = {r_val[W-1], r_val};
            assign w_up  = w_cur + c_step;
            assign w_dn  = w_cur - c_step;

            always_comb begin
                w_nxt = r_val;
                if (w_up_req) begin
                    w_nxt = (w_up > c_max) ? c_max[W-1:0] : w_up[W-1:0];
                end else if (w_dn_req) begin
                    w_nxt = (w_dn < c_min) ? c_min[W-1:0] : w_dn[W-1:0];
                end
            end
        end else begin : g_unsigned
            localparam logic [W:0] c_step = STEP[W:0];
            localparam logic [W:0] c_min  = MIN[W:0];
            localparam logic [W:0] c_max  = MAX[W:0];
            logic [W:0] w_cur;
            logic [W:0] w_up;
            logic [W:0] w_dn;

            assign w_cur = {1'b0, r_val};
            assign w_up  = w_cur + c_step;
            assign w_dn  = w_cur - c_step;

            always_comb begin
                w_nxt = r_val;
                if (w_up_req) begin
                    w_nxt = (w_up > c_max) ? c_max[W-1:0] : w_up[W-1:0];
                end else if (w_dn_req) begin
                    w_nxt = ((w_cur < c_step) || (w_dn < c_min)) ? c_min[W-1:0] : w_dn[W-1:0];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_val <= c_rst;
        end else begin
            r_val <= w_nxt;
        end
    end

    assign value     = r_val;
    assign value_nxt = w_nxt;

endmodule
`default_nettype wire

// File: rtl/frame_cfg_sched.sv
`default_nettype none
//==============================================================================
// Module      : frame_cfg_sched
// Description : Shadows brightness/contrast/mode requests and commits them on
//               the frame boundary, inserting one blanked frame on mode change.
// Revision    : 1.0 - initial release
//==============================================================================
module frame_cfg_sched
    import frame_cfg_pkg::*;
#(
    parameter int BRIGHT_W    = DEF_BRIGHT_W,
    parameter int BRIGHT_STEP = DEF_BRIGHT_STEP,
    parameter int CON_W       = DEF_CON_W,
    parameter int CON_DEF     = DEF_CON_DEF
) (
    input  wire logic         clk,
    input  wire logic         rst,
    frame_cfg_sched_if.slave  bus
);
    localparam logic [CON_W-1:0] c_con_def = CON_DEF[CON_W-1:0];

    logic [BRIGHT_W-1:0] w_pend_bright;
    logic [BRIGHT_W-1:0] w_pend_bright_nxt;
    logic [CON_W-1:0]    w_pend_con;
    logic [CON_W-1:0]    w_pend_con_nxt;
    logic [1:0]          r_pend_mode;
    logic [1:0]          w_pend_mode_nxt;

    logic [0:0]          r_state;
    logic [0:0]          w_state_nxt;
    logic [BRIGHT_W-1:0] r_bright;
    logic [BRIGHT_W-1:0] w_bright_nxt;
    logic [CON_W-1:0]    r_con;
    logic [CON_W-1:0]    w_con_nxt;
    logic [1:0]          r_mode;
    logic [1:0]          w_mode_nxt;
    logic [3:0]          r_mode_en;
    logic [3:0]          w_mode_en_nxt;
    logic                r_upd;
    logic                w_upd_nxt;
    logic                r_busy;
    logic                w_busy_nxt;

    logic                w_bright_dirty;
    logic                w_con_dirty;
    logic                w_mode_dirty;

    sat_step_reg #(
        .W       (BRIGHT_W),
        .SIGNED  (1'b1),
        .STEP    (BRIGHT_STEP),
        .MIN     (-(2 ** (BRIGHT_W - 1))),
        .MAX     ((2 ** (BRIGHT_W - 1)) - 1),
        .RST_VAL (0)
    ) u_pend_bright (
        .clk       (clk),
        .rst       (rst),
        .inc       (bus.binc),
        .dec       (bus.bdec),
        .value     (w_pend_bright),
        .value_nxt (w_pend_bright_nxt)
    );

    sat_step_reg #(
        .W       (CON_W),
        .SIGNED  (1'b0),
        .STEP    (1),
        .MIN     (0),
        .MAX     ((2 ** CON_W) - 1),
        .RST_VAL (CON_DEF)
    ) u_pend_con (
        .clk       (clk),
        .rst       (rst),
        .inc       (bus.cinc),
        .dec       (bus.cdec),
        .value     (w_pend_con),
        .value_nxt (w_pend_con_nxt)
    );

    // A locked mode_next is dropped outright rather than held for later.
    assign w_pend_mode_nxt = (bus.mode_next && !bus.mode_lock) ? r_pend_mode + 2'd1 : r_pend_mode;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend_mode <= MODE_PASS;
        end else begin
            r_pend_mode <= w_pend_mode_nxt;
        end
    end

    assign w_bright_dirty = (w_pend_bright != r_bright);
    assign w_con_dirty    = (w_pend_con != r_con);
    assign w_mode_dirty   = (r_pend_mode != r_mode);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ACTIVE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ACTIVE:  if (bus.frame_en && w_mode_dirty) w_state_nxt = BLANK;
            BLANK:   if (bus.frame_en) w_state_nxt = ACTIVE;
            default: w_state_nxt = ACTIVE;
        endcase
    end

    // Commits use the pending values registered before this cycle's pulses.
    always_comb begin
        w_bright_nxt  = r_bright;
        w_con_nxt     = r_con;
        w_mode_nxt    = r_mode;
        w_mode_en_nxt = r_mode_en;
        w_upd_nxt     = 1'b0;
        if (bus.frame_en) begin
            if (w_bright_dirty) begin
                w_bright_nxt = w_pend_bright;
                w_upd_nxt    = 1'b1;
            end
            if (w_con_dirty) begin
                w_con_nxt = w_pend_con;
                w_upd_nxt = 1'b1;
            end
            case (r_state)
                ACTIVE: begin
                    if (w_mode_dirty) begin
                        w_mode_en_nxt = 4'b0000;
                        w_upd_nxt     = 1'b1;
                    end
                end
                BLANK: begin
                    w_mode_nxt    = r_pend_mode;
                    w_mode_en_nxt = mode_onehot(r_pend_mode);
                    w_upd_nxt     = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign w_busy_nxt = (w_pend_bright_nxt != w_bright_nxt) ||
                        (w_pend_con_nxt != w_con_nxt) ||
                        (w_pend_mode_nxt != w_mode_nxt) ||
                        (w_state_nxt != ACTIVE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bright  <= '0;
            r_con     <= c_con_def;
            r_mode    <= MODE_PASS;
            r_mode_en <= 4'b0001;
            r_upd     <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_bright  <= w_bright_nxt;
            r_con     <= w_con_nxt;
            r_mode    <= w_mode_nxt;
            r_mode_en <= w_mode_en_nxt;
            r_upd     <= w_upd_nxt;
            r_busy    <= w_busy_nxt;
        end
    end

    assign bus.bright_off = r_bright;
    assign bus.con_gain   = r_con;
    assign bus.mode       = r_mode;
    assign bus.mode_en    = r_mode_en;
    assign bus.cfg_busy   = r_busy;
    assign bus.upd_strobe = r_upd;

endmodule
`default_nettype wire

// File: tb/tb_frame_cfg_sched.sv
`default_nettype none
//==============================================================================
// Module      : tb_frame_cfg_sched
// Description : Directed stimulus with a scoreboard of expected commit snapshots.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_frame_cfg_sched;

    typedef struct packed {
        logic [7:0] b;
        logic [3:0] c;
        logic [1:0] m;
        logic [3:0] en;
        logic       busy;
    } snap_t;

    logic  clk = 1'b0;
    logic  rst;
    snap_t sb[$];
    int    checks   = 0;
    int    failures = 0;

    always #5 clk = ~clk;

    frame_cfg_sched_if #(.BRIGHT_W(8), .CON_W(4)) bus ();

    frame_cfg_sched #(
        .BRIGHT_W    (8),
        .BRIGHT_STEP (8),
        .CON_W       (4),
        .CON_DEF     (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Every upd_strobe cycle must match the oldest expected commit.
    always @(negedge clk) begin : monitor
        snap_t s;
        if (bus.upd_strobe === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_upd", 32'd1, 32'd0);
            end else begin
                s = sb.pop_front();
                chk("upd_bright", {24'd0, bus.bright_off}, {24'd0, s.b});
                chk("upd_con",    {28'd0, bus.con_gain}, {28'd0, s.c});
                chk("upd_mode",   {30'd0, bus.mode},     {30'd0, s.m});
                chk("upd_mode_en",{28'd0, bus.mode_en},  {28'd0, s.en});
                chk("upd_busy",   {31'd0, bus.cfg_busy}, {31'd0, s.busy});
            end
        end
    end

    // Drives one cycle of pulses; entered and left just after a rising edge.
    task automatic drive(input logic bi, input logic bd, input logic ci,
                         input logic cd, input logic mn, input logic fe);
        bus.binc = bi; bus.bdec = bd; bus.cinc = ci; bus.cdec = cd;
        bus.mode_next = mn; bus.frame_en = fe;
        @(posedge clk); #1;
        bus.binc = 0; bus.bdec = 0; bus.cinc = 0; bus.cdec = 0;
        bus.mode_next = 0; bus.frame_en = 0;
    endtask

    task automatic pulses(input int n, input logic bi, input logic bd,
                          input logic ci, input logic cd, input logic mn);
        for (int i = 0; i < n; i++) drive(bi, bd, ci, cd, mn, 1'b0);
    endtask

    task automatic frame_upd(input logic [7:0] b, input logic [3:0] c, input logic [1:0] m,
                             input logic [3:0] en, input logic busy);
        sb.push_back('{b: b, c: c, m: m, en: en, busy: busy});
        drive(0, 0, 0, 0, 0, 1);
    endtask

    task automatic frame_none(input string name);
        drive(0, 0, 0, 0, 0, 1);
        chk(name, {31'd0, bus.upd_strobe}, 32'd0);
    endtask

    task automatic chk_outs(input string name, input logic [7:0] b, input logic [3:0] c,
                            input logic [1:0] m, input logic [3:0] en, input logic busy);
        chk({name, "_bright"}, {24'd0, bus.bright_off}, {24'd0, b});
        chk({name, "_con"},    {28'd0, bus.con_gain},   {28'd0, c});
        chk({name, "_mode"},   {30'd0, bus.mode},       {30'd0, m});
        chk({name, "_mode_en"},{28'd0, bus.mode_en},    {28'd0, en});
        chk({name, "_busy"},   {31'd0, bus.cfg_busy},   {31'd0, busy});
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        rst = 1'b1;
        bus.binc = 0; bus.bdec = 0; bus.cinc = 0; bus.cdec = 0;
        bus.mode_next = 0; bus.mode_lock = 0; bus.frame_en = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk_outs("reset", 8'd0, 4'd4, 2'd0, 4'b0001, 1'b0);
        chk("reset_upd", {31'd0, bus.upd_strobe}, 32'd0);

        // Three brightness steps stay pending until the frame strobe.
        pulses(1, 1, 0, 0, 0, 0);
        chk("busy_first_pulse", {31'd0, bus.cfg_busy}, 32'd1);
        pulses(2, 1, 0, 0, 0, 0);
        chk_outs("pend3", 8'd0, 4'd4, 2'd0, 4'b0001, 1'b1);
        frame_upd(8'd24, 4'd4, 2'd0, 4'b0001, 1'b0);
        drive(0, 0, 0, 0, 0, 0);
        chk("upd_one_cycle", {31'd0, bus.upd_strobe}, 32'd0);

        // Saturation at both brightness rails and the contrast ceiling.
        pulses(17, 1, 0, 0, 0, 0);
        frame_upd(8'd127, 4'd4, 2'd0, 4'b0001, 1'b0);
        pulses(40, 0, 1, 0, 0, 0);
        frame_upd(8'h80, 4'd4, 2'd0, 4'b0001, 1'b0);
        pulses(20, 0, 0, 1, 0, 0);
        frame_upd(8'h80, 4'd15, 2'd0, 4'b0001, 1'b0);

        // Opposing pulses cancel: nothing becomes dirty.
        pulses(5, 1, 1, 1, 1, 0);
        chk("cancel_busy", {31'd0, bus.cfg_busy}, 32'd0);
        frame_none("cancel_noupd");
        chk_outs("cancel", 8'h80, 4'd15, 2'd0, 4'b0001, 1'b0);

        // Mode change through a blanked frame, with a further step during BLANK.
        pulses(1, 0, 0, 0, 0, 1);
        chk("mode_pend_busy", {31'd0, bus.cfg_busy}, 32'd1);
        frame_upd(8'h80, 4'd15, 2'd0, 4'b0000, 1'b1);
        pulses(1, 0, 0, 0, 0, 1);
        frame_upd(8'h80, 4'd15, 2'd2, 4'b0100, 1'b0);
        pulses(3, 0, 0, 0, 0, 1);
        frame_upd(8'h80, 4'd15, 2'd2, 4'b0000, 1'b1);
        frame_upd(8'h80, 4'd15, 2'd1, 4'b0010, 1'b0);

        // Locked mode_next is dropped; a pulse on the strobe cycle waits a frame.
        bus.mode_lock = 1'b1;
        pulses(1, 0, 0, 0, 0, 1);
        chk("lock_busy", {31'd0, bus.cfg_busy}, 32'd0);
        frame_none("lock_noupd");
        chk_outs("lock", 8'h80, 4'd15, 2'd1, 4'b0010, 1'b0);
        bus.mode_lock = 1'b0;
        drive(1, 0, 0, 0, 0, 1);
        chk("coinc_noupd", {31'd0, bus.upd_strobe}, 32'd0);
        chk_outs("coinc", 8'h80, 4'd15, 2'd1, 4'b0010, 1'b1);
        frame_upd(8'h88, 4'd15, 2'd1, 4'b0010, 1'b0);

        // Reset in the middle of BLANK discards everything pending.
        pulses(1, 0, 0, 0, 0, 1);
        frame_upd(8'h88, 4'd15, 2'd1, 4'b0000, 1'b1);
        pulses(2, 0, 0, 1, 0, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk_outs("rst_blank", 8'd0, 4'd4, 2'd0, 4'b0001, 1'b0);
        chk("rst_blank_upd", {31'd0, bus.upd_strobe}, 32'd0);
        frame_none("post_rst_noupd");
        chk_outs("post_rst", 8'd0, 4'd4, 2'd0, 4'b0001, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/frame_cfg_sched.md
Name: frame_cfg_sched

Overview:
- Configuration scheduler between the user-input/control stage and the pixel datapath (brightness/contrast, grayscale, green screen, colour detect).
- Accepts single-cycle adjust/mode pulses at any time and holds them in pending (shadow) registers.
- Commits them to the datapath only on the frame boundary strobe, so no frame is ever drawn with mixed settings.
- Filter-mode changes go through one fully blanked-filter frame (pass-through) before the new mode is enabled.

Parameters:
- BRIGHT_W, 8, width of signed brightness offset.
- BRIGHT_STEP, 8, offset change per binc/bdec pulse.
- CON_W, 4, width of unsigned contrast gain.
- CON_DEF, 4, contrast gain after reset (unity gain = 4, i.e. gain/4).

Ports:
- clk, input, 1, pixel clock; the only clock.
- rst, input, 1, synchronous, active-high reset.
- frame_en, input, 1, one-cycle strobe at frame boundary (row=480, col=640).
- binc, input, 1, one-cycle pulse: raise brightness.
- bdec, input, 1, one-cycle pulse: lower brightness.
- cinc, input, 1, one-cycle pulse: raise contrast.
- cdec, input, 1, one-cycle pulse: lower contrast.
- mode_next, input, 1, one-cycle pulse: advance pending filter mode.
- mode_lock, input, 1, level; when 1, mode_next is ignored.
- bright_off, output, BRIGHT_W, committed signed brightness offset.
- con_gain, output, CON_W, committed contrast gain.
- mode, output, 2, committed mode: 0 pass, 1 gray, 2 green, 3 colour detect.
- mode_en, output, 4, one-hot filter enable for committed mode; 0 while blanking.
- cfg_busy, output, 1, high while any pending value differs from committed or state is not ACTIVE.
- upd_strobe, output, 1, one-cycle pulse on the cycle that committed outputs change.

Behaviour:
- Reset values (clocked, rst has priority over everything):
  - bright_off=0, con_gain=CON_DEF, mode=0, mode_en=4'b0001.
  - cfg_busy=0, upd_strobe=0, state=ACTIVE.
  - All pending registers equal committed values; all dirty flags clear.
- Pending brightness: signed, saturating; clamp to [-2^(BRIGHT_W-1), 2^(BRIGHT_W-1)-1].
  - For defaults: 120+8 -> 127, and 127 stays at 127; -128-8 -> -128.
  - Intermediate arithmetic uses BRIGHT_W+1 bits.
- Pending contrast: unsigned, step 1, saturate at 0 and 2^CON_W-1.
- binc and bdec in the same cycle: no change. Same rule for cinc and cdec.
- Pending mode: mode_next with mode_lock=0 increments modulo 4 (3 -> 0). A mode_next pulse while mode_lock=1 is dropped, not deferred.
- Dirty flags: set when the pending value differs from the committed value. Adjusting back to the committed value clears the flag.
- Same-cycle pulse and frame_en: the commit uses the pending value registered before that cycle. The pulse updates pending and is committed at the next frame_en.
- FSM states:
  - ACTIVE: on frame_en:
    - Commit bright/contrast if dirty and pulse upd_strobe.
    - If mode is dirty, go to BLANK and set mode_en=0 on the same commit edge; upd_strobe also pulses.
  - BLANK: mode_en=0, mode holds the old value, bright/contrast keep committing normally at frame_en. On the next frame_en:
    - mode <= current pending mode (latest value, including changes made during BLANK).
    - mode_en <= one-hot(mode); pulse upd_strobe; go to ACTIVE.
    - If pending mode equals the old mode, still exit BLANK and restore the old mode.
- Latency: outputs change on the clock edge that samples frame_en=1, i.e. they are visible in the cycle after the strobe. upd_strobe is high for exactly that one cycle.
- Pulses with no frame_en: pending values accumulate indefinitely and outputs are unchanged.
- rst during BLANK: return to ACTIVE with reset values; pending changes are discarded.
- cfg_busy is registered and derived from next-state dirty/state, so it has zero extra latency relative to the pending registers.

Decomposition:
- Package frame_cfg_pkg:
  - Mode encoding constants MODE_PASS/GRAY/GREEN/CDET.
  - FSM state encoding ACTIVE/BLANK.
  - Default widths.
- One sub-module sat_step_reg (parameterised width, signedness, step, min, max, reset value; inc/dec inputs; value output). It is instantiated for pending brightness and pending contrast.
- Commit logic and FSM stay in the top module.

Test Plan:
1. Reset, then 3 binc pulses, no frame_en -> bright_off=0, cfg_busy=1. Then frame_en -> next cycle bright_off=24, upd_strobe=1 for one cycle, cfg_busy=0.
2. 17 binc pulses then frame_en -> bright_off=127. 40 bdec pulses then frame_en -> bright_off=-128. cinc x20 then frame_en -> con_gain=15.
3. binc+bdec and cinc+cdec asserted together for 5 cycles, then frame_en -> no output change, upd_strobe=0, cfg_busy stays 0.
4. Mode change:
   - mode_next x1, then frame_en: mode_en=0, mode=0, state BLANK.
   - mode_next x1 during BLANK, then frame_en: mode=2, mode_en=4'b0100.
   - mode_next x3 -> wraps to 1.
5. mode_lock=1 plus mode_next, then frame_en -> mode unchanged, no BLANK. binc pulse coincident with frame_en -> bright_off unchanged until the following frame_en (+8).
6. Mode change to BLANK plus 2 cinc, then rst mid-BLANK -> con_gain=4, mode=0, mode_en=4'b0001, cfg_busy=0. No commit at the next frame_en.
